// File: rtl/conv_tile_mac.sv
// ============================================================================
// conv_tile_mac : tile-stride convolution over a padded map, one MAC per cycle
// Revision 1.0
// ============================================================================
`default_nettype none

module conv_tile_mac #(
    parameter int SIZE        = 5,
    parameter int FILTER_SIZE = 3,
    parameter int PADDED      = SIZE + ((FILTER_SIZE - (SIZE % FILTER_SIZE)) % FILTER_SIZE),
    parameter int TILES       = PADDED / FILTER_SIZE,
    parameter int IW          = (TILES > 1) ? $clog2(TILES) : 1
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic [PADDED-1:0][PADDED-1:0][31:0]           in_array,
    input  logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][31:0] kernel,
    output logic [31:0]                                   out_data,
    output logic [IW-1:0]                                 out_row,
    output logic [IW-1:0]                                 out_col,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          busy,
    output logic                                          done
);

    localparam int FW = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
    localparam int RW = (PADDED > 1) ? $clog2(PADDED) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PADDED-1:0][PADDED-1:0][31:0]           map_q;
    logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][31:0] ker_q;
    logic [31:0]   acc;
    logic [FW-1:0] r_cnt, c_cnt;
    logic [IW-1:0] ti, tj;
    logic [RW-1:0] row_idx, col_idx;
    logic [31:0]   prod, mac_sum;
    logic          last_elem, last_tile;

    // k is tracked as (r,c) counters so no divider is needed for k/F and k%F
    assign row_idx   = RW'(ti * FILTER_SIZE + r_cnt);
    assign col_idx   = RW'(tj * FILTER_SIZE + c_cnt);
    assign prod      = map_q[row_idx][col_idx] * ker_q[r_cnt][c_cnt];
    assign mac_sum   = acc + prod;
    assign last_elem = (r_cnt == FW'(FILTER_SIZE - 1)) && (c_cnt == FW'(FILTER_SIZE - 1));
    assign last_tile = (ti == IW'(TILES - 1)) && (tj == IW'(TILES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_MAC;
            end
            S_MAC: begin
                busy = 1'b1;
                if (last_elem) state_nxt = S_OUT;
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = last_tile ? S_DONE : S_MAC;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            map_q    <= '0;
            ker_q    <= '0;
            acc      <= '0;
            r_cnt    <= '0;
            c_cnt    <= '0;
            ti       <= '0;
            tj       <= '0;
            out_data <= '0;
            out_row  <= '0;
            out_col  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        map_q <= in_array;
                        ker_q <= kernel;
                        acc   <= '0;
                        r_cnt <= '0;
                        c_cnt <= '0;
                        ti    <= '0;
                        tj    <= '0;
                    end
                end
                S_MAC: begin
                    acc <= mac_sum;
                    if (last_elem) begin
                        out_data <= mac_sum;
                        out_row  <= ti;
                        out_col  <= tj;
                    end else if (c_cnt == FW'(FILTER_SIZE - 1)) begin
                        c_cnt <= '0;
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        c_cnt <= c_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    // Output registers are untouched here, so they hold under back-pressure
                    if (out_ready && !last_tile) begin
                        acc   <= '0;
                        r_cnt <= '0;
                        c_cnt <= '0;
                        if (tj == IW'(TILES - 1)) begin
                            tj <= '0;
                            ti <= ti + 1'b1;
                        end else begin
                            tj <= tj + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_tile_mac.sv
// Directed bench for conv_tile_mac: SIZE=5 (padded to 6) and SIZE=6 instances, F=3.
`timescale 1ns/1ps
`default_nettype none

module tb_conv_tile_mac;

    localparam int F  = 3;
    localparam int P  = 6;
    localparam int IW = 1;

    logic clk = 1'b0;
    logic reset, start, start6, out_ready;
    logic [P-1:0][P-1:0][31:0] in_array, in_array6;
    logic [F-1:0][F-1:0][31:0] kernel;
    logic [31:0]   out_data, out_data6;
    logic [IW-1:0] out_row, out_col, out_row6, out_col6;
    logic          out_valid, busy, done, out_valid6, busy6, done6;

    always #5 clk = ~clk;

    conv_tile_mac #(.SIZE(5), .FILTER_SIZE(3)) dut (
        .clk(clk), .reset(reset), .start(start), .in_array(in_array), .kernel(kernel),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    conv_tile_mac #(.SIZE(6), .FILTER_SIZE(3)) dut6 (
        .clk(clk), .reset(reset), .start(start6), .in_array(in_array6), .kernel(kernel),
        .out_data(out_data6), .out_row(out_row6), .out_col(out_col6), .out_valid(out_valid6),
        .out_ready(out_ready), .busy(busy6), .done(done6)
    );

    int total  = 0;
    int passed = 0;
    logic [31:0] res_data[$];
    int res_row[$];
    int res_col[$];
    int first_valid, done_at, done_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic fill_ones_padded();
        for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++)
                in_array[r][c] = (r < 5 && c < 5) ? 32'd1 : 32'd0;
    endtask

    task automatic fill_kernel_ones();
        for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++)
                kernel[r][c] = 32'd1;
    endtask

    // Offsets n count rising edges after the accepted-start edge; sampling is on the falling edge.
    task automatic run_map(input bit sel, input int max_n, input int stall_len,
                           input bit perturb, input bit pulse);
        int stall_left;
        res_data.delete();
        res_row.delete();
        res_col.delete();
        first_valid = -1;
        done_at     = -1;
        done_cnt    = 0;
        stall_left  = stall_len;
        out_ready   = 1'b1;
        @(negedge clk);
        if (sel) start6 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start6 = 1'b0;
        for (int n = 1; n <= max_n; n++) begin
            logic v, d, b;
            logic [31:0] dat;
            int r, c;
            @(negedge clk);
            start = pulse && (n == 3 || n == 9 || n == 40);
            if (perturb && n == 1)
                for (int i = 0; i < P; i++)
                    for (int j = 0; j < P; j++)
                        in_array[i][j] = 32'd7;
            v   = sel ? out_valid6 : out_valid;
            d   = sel ? done6 : done;
            b   = sel ? busy6 : busy;
            dat = sel ? out_data6 : out_data;
            r   = sel ? int'(out_row6) : int'(out_row);
            c   = sel ? int'(out_col6) : int'(out_col);
            if (v && first_valid < 0) first_valid = n;
            if (v && res_data.size() == 1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                check("stall_hold_data", dat, 32'd6);
                check("stall_hold_row", 32'(r), 32'd0);
                check("stall_hold_col", 32'(c), 32'd1);
            end else begin
                out_ready = 1'b1;
            end
            if (v && out_ready) begin
                res_data.push_back(dat);
                res_row.push_back(r);
                res_col.push_back(c);
            end
            if (d) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
                check("busy_low_in_done", 32'(b), 32'd0);
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_map(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp_d[4];
        exp_d = '{e0, e1, e2, e3};
        check({tag, "_count"}, 32'(res_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < res_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), res_data[i], exp_d[i]);
            check($sformatf("%s_row%0d", tag, i), 32'(res_row[i]), 32'(i / 2));
            check($sformatf("%s_col%0d", tag, i), 32'(res_col[i]), 32'(i % 2));
        end
    endtask

    initial begin
        int vcnt, dcnt;
        reset     = 1'b1;
        start     = 1'b0;
        start6    = 1'b0;
        out_ready = 1'b1;
        in_array  = '0;
        in_array6 = '0;
        kernel    = '0;
        repeat (3) @(negedge clk);
        check("rst_data", out_data, 32'd0);
        check("rst_row", 32'(out_row), 32'd0);
        check("rst_col", 32'(out_col), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // All-ones 5x5 inside a zero-padded 6x6: full tile 9, edge tiles 6, corner 4
        fill_ones_padded();
        fill_kernel_ones();
        run_map(1'b0, 60, 0, 1'b0, 1'b0);
        check_map("ones", 32'd9, 32'd6, 32'd6, 32'd4);
        check("ones_first_valid", 32'(first_valid), 32'd9);
        check("ones_done_at", 32'(done_at), 32'd40);
        check("ones_done_cnt", 32'(done_cnt), 32'd1);

        run_map(1'b0, 60, 5, 1'b0, 1'b0);
        check_map("stall", 32'd9, 32'd6, 32'd6, 32'd4);
        check("stall_done_at", 32'(done_at), 32'd45);
        check("stall_done_cnt", 32'(done_cnt), 32'd1);

        fill_ones_padded();
        run_map(1'b0, 60, 0, 1'b1, 1'b1);
        check_map("isol", 32'd9, 32'd6, 32'd6, 32'd4);
        check("isol_done_cnt", 32'(done_cnt), 32'd1);

        // Kernel k=0..8 row-major: (0,1) uses kernel cols 0-1, (1,0) rows 0-1, (1,1) the 2x2 corner
        fill_ones_padded();
        for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++)
                kernel[r][c] = 32'(r * F + c);
        run_map(1'b0, 60, 0, 1'b0, 1'b0);
        check_map("kidx", 32'd36, 32'd21, 32'd15, 32'd8);

        // Reset in the middle of MAC: out_data/row/col still hold the previous map's last tile
        fill_kernel_ones();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_data", out_data, 32'd0);
        check("midrst_row", 32'(out_row), 32'd0);
        check("midrst_col", 32'(out_col), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        vcnt = 0;
        dcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
            if (done) dcnt++;
        end
        check("midrst_no_valid", 32'(vcnt), 32'd0);
        check("midrst_no_done", 32'(dcnt), 32'd0);
        run_map(1'b0, 60, 0, 1'b0, 1'b0);
        check("restart_first_valid", 32'(first_valid), 32'd9);
        check("restart_first_data", (res_data.size() > 0) ? res_data[0] : 32'hDEAD_BEEF, 32'd9);

        // Nine 0xFFFFFFFF terms wrap to -9
        in_array = '0;
        for (int r = 0; r < F; r++)
            for (int c = 0; c < F; c++)
                in_array[r][c] = 32'hFFFF_FFFF;
        run_map(1'b0, 60, 0, 1'b0, 1'b0);
        check_map("wrap", 32'hFFFF_FFF7, 32'd0, 32'd0, 32'd0);

        // Unpadded 6x6, A[r][c]=6r+c: tile (0,0)=63, +3 per element per column tile, +18 per row tile
        for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++)
                in_array6[r][c] = 32'(r * 6 + c);
        run_map(1'b1, 60, 0, 1'b0, 1'b0);
        check_map("s6", 32'd63, 32'd90, 32'd225, 32'd252);
        check("s6_done_at", 32'(done_at), 32'd40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
